rst_req: RTL and testbench

Reset-request initiator feeding the active-low external reset input of the board reset generator. It collects three reset sources: a software request over the IO bus, a watchdog timeout, and a debounced push-button. It emits one clean, fixed-length active-low request pulse and records which source(s) caused it in a cause register. After reset, software reads that register to tell a watchdog recovery from a deliberate or manual restart.

---
 rtl/rst_req_pkg.sv | 19 +
 rtl/rst_req_btn_debounce.sv | 49 ++++
 rtl/rst_req.sv | 147 ++++++++++++++
 tb/tb_rst_req.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_req_pkg.sv
// rst_req_pkg: shared constants for the reset-request initiator.
// Cause bit positions, IO addresses and FSM state encoding.
package rst_req_pkg;

  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WD  = 1;
  localparam int CAUSE_BTN = 2;

  localparam logic ADDR_CTRL  = 1'b0;
  localparam logic ADDR_CAUSE = 1'b1;

  // IDLE is the all-zero encoding so an uninitialised power-up lands there.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/rst_req_btn_debounce.sv
// btn_debounce: 2-FF synchronizer and stability counter for the button.
// o_level is 1 while pressed; o_press strobes for one cycle on a press.
module btn_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  logic [1:0]               r_sync;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     r_level;
  logic                     r_press;
  logic                     w_raw;

  assign w_raw   = ~r_sync[1];
  assign o_level = r_level;
  assign o_press = r_press;

  // Synchronize the raw active-low input; reset reads as released.
  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_btn_n};
  end

  // Flip the level once the input has disagreed for 2^DEBOUNCE_BITS cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_raw == r_level) begin
        r_cnt <= '0;
      end else if (&r_cnt) begin
        r_cnt   <= '0;
        r_level <= w_raw;
        r_press <= w_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_req.sv
// rst_req: collects software, watchdog and button reset requests and
// emits one fixed-length active-low pulse, recording the cause.
module rst_req
  import rst_req_pkg::*;
#(
  parameter int PULSE_LEN     = 16,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        rd,
  input  logic        addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ack,
  input  logic        tick,
  input  logic        btn_in_n,
  output logic        rst_req_n
);

  localparam int CW = $clog2(PULSE_LEN);
  localparam logic [CW-1:0] PMAX = CW'(PULSE_LEN - 1);

  // FSM, pulse counter, request and cause survive rst_n: the reset this
  // block requests must not cut its own pulse or wipe the cause. Their
  // all-zero power-up state is IDLE, no request, empty cause.
  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_pcnt;
  logic [CW-1:0] w_pcnt_nx;
  logic          r_req;
  logic          w_req_nx;
  logic [2:0]    r_cause;

  logic [15:0]   r_wd_t;
  logic [15:0]   r_wd_cnt;
  logic          r_ack;
  logic [31:0]   r_rd_data;

  logic          w_kick;
  logic          w_sw_req;
  logic          w_wd_req;
  logic          w_btn_lvl;
  logic          w_btn_press;
  logic [2:0]    w_reqs;
  logic [2:0]    w_clr;
  logic          w_unused;

  assign w_kick   = rst_n & wr & (addr == ADDR_CTRL);
  assign w_sw_req = w_kick & wr_data[31];
  assign w_wd_req = rst_n & tick & ~w_kick & (|r_wd_t)
                  & (r_wd_cnt == 16'd1);
  assign w_clr    = (rst_n & wr & (addr == ADDR_CAUSE))
                  ? wr_data[2:0] : 3'b000;
  assign w_unused = ^wr_data[30:16];

  assign w_reqs[CAUSE_SW]  = w_sw_req;
  assign w_reqs[CAUSE_WD]  = w_wd_req;
  assign w_reqs[CAUSE_BTN] = w_btn_press;

  assign rst_req_n = ~r_req;
  assign ack       = r_ack;
  assign rd_data   = r_rd_data;

  btn_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn_n(btn_in_n),
    .o_level(w_btn_lvl),
    .o_press(w_btn_press)
  );

  // Watchdog timeout and countdown; a kick beats a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_t   <= '0;
      r_wd_cnt <= '0;
    end else if (w_kick) begin
      r_wd_t   <= wr_data[15:0];
      r_wd_cnt <= wr_data[15:0];
    end else if (tick && (|r_wd_t) && (|r_wd_cnt)) begin
      r_wd_cnt <= r_wd_cnt - 16'd1;
    end
  end

  // Registered bus response: ack and data one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ack     <= rd | wr;
      r_rd_data <= '0;
      if (rd) begin
        if (addr == ADDR_CAUSE) r_rd_data <= {29'h0, r_cause};
        else                    r_rd_data <= {16'h0, r_wd_cnt};
      end
    end
  end

  // Cause bits: sticky OR of requests, write-one-to-clear; set wins.
  always_ff @(posedge clk) begin
    r_cause <= (r_cause & ~w_clr) | w_reqs;
  end

  // FSM state, pulse counter and request output.
  always_ff @(posedge clk) begin
    r_state <= w_state_nx;
    r_pcnt  <= w_pcnt_nx;
    r_req   <= w_req_nx;
  end

  // Next-state: start on any request, hold PULSE_LEN, wait for release.
  always_comb begin
    w_state_nx = r_state;
    w_pcnt_nx  = r_pcnt;
    w_req_nx   = r_req;
    unique case (r_state)
      IDLE: begin
        if (|w_reqs) begin
          w_state_nx = PULSE;
          w_pcnt_nx  = '0;
          w_req_nx   = 1'b1;
        end
      end
      PULSE: begin
        if (r_pcnt == PMAX) begin
          w_state_nx = WAIT_REL;
          w_req_nx   = 1'b0;
        end else begin
          w_pcnt_nx = r_pcnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!w_btn_lvl) w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_req_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_req.sv
// tb_rst_req: directed and random stimulus for rst_req, compared each
// cycle against a behavioural model of the request/cause/watchdog rules.
module tb_rst_req;

  localparam int PL  = 16;
  localparam int DB  = 4;
  localparam int NDB = 1 << DB;
  localparam int HN  = 16384;

  logic        clk = 1'b0;
  logic        rst_n, wr, rd, addr, tick, btn_in_n;
  logic [31:0] wr_data, rd_data;
  logic        ack, rst_req_n;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus for the current cycle
  bit          s_rst = 1'b0, s_wr, s_rd, s_addr, s_tick, s_btn = 1'b1;
  logic [31:0] s_data = '0;

  // reference model
  bit          hist [0:HN-1];
  logic [15:0] m_T = '0, m_cnt = '0;
  logic [2:0]  m_cause = '0;
  int          m_low = 0;
  bit          m_wait = 1'b0;
  bit          m_lvl = 1'b0;
  logic        e_ack = 1'b0;
  logic [31:0] e_rd = '0;

  // pulse observer
  int run = 0, p_start = -1, n_pulses = 0;

  rst_req #(.PULSE_LEN(PL), .DEBOUNCE_BITS(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ack      (ack),
    .tick     (tick),
    .btn_in_n (btn_in_n),
    .rst_req_n(rst_req_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Debounced level: pressed once the button was low over the whole
  // window seen through the 2-cycle synchronizer, released once high.
  function automatic bit lvl_at(int c, bit prev);
    int lo = 0;
    int hi = 0;
    for (int k = c - 2 - NDB; k <= c - 3; k++) begin
      if (k < 0 || hist[k]) hi++;
      else lo++;
    end
    if (lo == NDB) return 1'b1;
    if (hi == NDB) return 1'b0;
    return prev;
  endfunction

  task automatic cycle();
    bit         lv, press, kick;
    logic [2:0] req, clr;
    rst_n = s_rst; wr = s_wr; rd = s_rd; addr = s_addr;
    wr_data = s_data; tick = s_tick; btn_in_n = s_btn;
    if (cyc < HN) hist[cyc] = s_btn;
    @(negedge clk);
    chk("rst_req_n", rst_req_n, (m_low > 0) ? 0 : 1);
    chk("ack", ack, e_ack);
    chk("rd_data", rd_data, e_rd);
    if (rst_req_n === 1'b0) begin
      if (run == 0) p_start = cyc;
      run++;
    end else if (run > 0) begin
      chk("pulse_len", run, PL);
      n_pulses++;
      run = 0;
    end
    lv = lvl_at(cyc, m_lvl);
    press = lv & ~m_lvl;
    m_lvl = lv;
    kick = s_rst && s_wr && !s_addr;
    req = '0;
    if (kick && s_data[31]) req[0] = 1'b1;
    if (s_rst && s_tick && !kick && m_T != 0 && m_cnt == 1) req[1] = 1'b1;
    if (press) req[2] = 1'b1;
    e_ack = s_rst && (s_wr || s_rd);
    e_rd = '0;
    if (s_rst && s_rd)
      e_rd = s_addr ? {29'h0, m_cause} : {16'h0, m_cnt};
    clr = (s_rst && s_wr && s_addr) ? s_data[2:0] : 3'b000;
    m_cause = (m_cause & ~clr) | req;
    if (!s_rst) begin
      m_T = '0; m_cnt = '0;
    end else if (kick) begin
      m_T = s_data[15:0]; m_cnt = m_T;
    end else if (s_tick && m_T != 0 && m_cnt != 0) begin
      m_cnt = m_cnt - 16'd1;
    end
    if (m_low > 0) begin
      m_low--;
      if (m_low == 0) m_wait = 1'b1;
    end else if (m_wait) begin
      if (!lv) m_wait = 1'b0;
    end else if (req != 0) begin
      m_low = PL;
    end
    @(posedge clk);
    #1;
    cyc++;
    s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr_reg(input bit a, input logic [31:0] d);
    s_wr = 1'b1; s_addr = a; s_data = d;
    cycle();
  endtask

  task automatic rd_reg(input string tag, input bit a,
                        input logic [31:0] want);
    s_rd = 1'b1; s_addr = a;
    cycle();
    chk(tag, rd_data, want);
  endtask

  initial begin
    int pb, t3, np, btn_left, hi_run, op;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = 1'b0; wr_data = '0;
    tick = 1'b0; btn_in_n = 1'b1;
    s_wr = 1'b0; s_rd = 1'b0; s_addr = 1'b0; s_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset, then software request at cycle 10 with reset mid-pulse
    s_rst = 1'b0; cycle();
    s_rst = 1'b0; cycle();
    s_rst = 1'b0; cycle();
    idle(7);
    wr_reg(1'b0, 32'h8000_0000);
    idle(4);
    s_rst = 1'b0; cycle();
    idle(20);
    chk("sw_start", p_start, 11);
    chk("sw_npulse", n_pulses, 1);
    rd_reg("sw_cause", 1'b1, 32'h1);
    wr_reg(1'b1, 32'h7);

    // watchdog expiry after three ticks, no refire
    wr_reg(1'b0, 32'd3);
    idle(2);
    s_tick = 1'b1; cycle(); idle(2);
    s_tick = 1'b1; cycle(); idle(2);
    t3 = cyc;
    s_tick = 1'b1; cycle();
    idle(25);
    chk("wd_start", p_start, t3 + 1);
    rd_reg("wd_cause", 1'b1, 32'h2);
    rd_reg("wd_cnt0", 1'b0, 32'h0);
    s_tick = 1'b1; cycle();
    idle(20);
    chk("wd_once", n_pulses, 2);
    wr_reg(1'b1, 32'h7);

    // kick coincident with the expiring tick
    wr_reg(1'b0, 32'd2);
    idle(2);
    s_tick = 1'b1; cycle(); idle(2);
    s_tick = 1'b1;
    wr_reg(1'b0, 32'd2);
    rd_reg("kick_cnt", 1'b0, 32'd2);
    idle(5);
    chk("kick_nopulse", n_pulses, 2);
    wr_reg(1'b0, 32'd0);

    // 10-cycle glitch
    s_btn = 1'b0; idle(10);
    s_btn = 1'b1; idle(30);
    chk("glitch", n_pulses, 2);

    // 40-cycle press; sw request while held is absorbed
    pb = cyc;
    s_btn = 1'b0; idle(36);
    rd_reg("btn_cause", 1'b1, 32'h4);
    idle(1);
    wr_reg(1'b0, 32'h8000_0000);
    idle(1);
    s_btn = 1'b1; idle(45);
    chk("btn_start", p_start, pb + 19);
    chk("btn_npulse", n_pulses, 3);
    rd_reg("held_cause", 1'b1, 32'h5);
    wr_reg(1'b1, 32'h7);

    // watchdog expiry then software request inside the same pulse
    wr_reg(1'b0, 32'd1);
    idle(2);
    t3 = cyc;
    s_tick = 1'b1; cycle();
    wr_reg(1'b0, 32'h8000_0000);
    idle(25);
    chk("dual_npulse", n_pulses, 4);
    chk("dual_start", p_start, t3 + 1);
    rd_reg("dual_cause", 1'b1, 32'h3);
    wr_reg(1'b1, 32'h1);
    rd_reg("w1c_cause", 1'b1, 32'h2);
    wr_reg(1'b1, 32'h7);

    // random traffic
    np = n_pulses;
    btn_left = 50;
    hi_run = 0;
    repeat (2000) begin
      if (btn_left == 0) begin
        s_btn = ~s_btn;
        btn_left = s_btn ? int'($urandom_range(1, 60))
                         : int'($urandom_range(1, 40));
      end
      btn_left--;
      if (s_btn) hi_run++;
      else hi_run = 0;
      s_tick = ($urandom_range(0, 3) == 0);
      op = int'($urandom_range(0, 15));
      if (op == 0 && hi_run > NDB + 4) begin
        s_rst = 1'b0;
      end else if (op == 1 || op == 2) begin
        s_wr = 1'b1; s_addr = 1'b0;
        s_data = {1'($urandom_range(0, 7) == 0), 15'($urandom),
                  16'($urandom_range(0, 6))};
      end else if (op == 3) begin
        s_wr = 1'b1; s_addr = 1'b1;
        s_data = {29'h0, 3'($urandom)};
      end else if (op >= 4 && op <= 6) begin
        s_rd = 1'b1; s_addr = 1'($urandom);
      end
      cycle();
    end
    s_btn = 1'b1;
    idle(100);
    if (n_pulses == np) chk("rand_pulses", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
